// File: rtl/sha256_reg_driver.sv
// ---------------------------------------------------------------------------
// sha256_reg_driver
//   Bus initiator for the SHA-256 register block. Accepts a 512-bit block on a
//   valid/ready port, waits for the core to be READY, writes the 16 BLOCK words
//   and CTRL (INIT/NEXT/MODE), polls STATUS until the digest is VALID, reads the
//   8 DIGEST words and presents the 256-bit digest on a valid/ready port.
//   Bus errors and poll timeouts abort the block and pulse drv_error.
//
//   Optional feature macro: SHA256_DRV_ZEROIZE_EN
//     defined   : after the digest handshake one CTRL write of 'h8 (ZEROIZE) is
//                 issued and dig_data is cleared in the same cycle.
//     undefined : DONE returns straight to IDLE and dig_data is retained.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   blk_valid/blk_ready      block request handshake
//   blk_data [511:0]         block, word0 in [511:480]
//   blk_first, blk_mode      1: INIT / 0: NEXT; CTRL.MODE (1 = SHA-256)
//   dig_valid/dig_ready      digest handshake
//   dig_data [255:0]         DIGEST[0] in [255:224] ... DIGEST[7] in [31:0]
//   drv_error                one-cycle pulse on bus error or poll timeout
//   cs, we, address,         register bus initiator side, one access per cycle,
//   write_data, read_data,   read_data and err are valid in the same cycle
//   err                      as cs
// ---------------------------------------------------------------------------
module sha256_reg_driver #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] CTRL_ADDR   = 'h10,
  parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR = 'h18,
  parameter logic [ADDR_WIDTH-1:0] BLOCK_ADDR  = 'h80,
  parameter logic [ADDR_WIDTH-1:0] DIGEST_ADDR = 'h100,
  parameter int                    TIMEOUT     = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  blk_valid,
  output logic                  blk_ready,
  input  logic [511:0]          blk_data,
  input  logic                  blk_first,
  input  logic                  blk_mode,
  output logic                  dig_valid,
  input  logic                  dig_ready,
  output logic [255:0]          dig_data,
  output logic                  drv_error,
  output logic                  cs,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  err
);

  localparam int POLL_MIN = $clog2(TIMEOUT + 1);
  localparam int POLL_W   = (POLL_MIN > 10) ? POLL_MIN : 10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_RDY,
    S_WR_BLK,
    S_WR_CTRL,
    S_POLL_BUSY,
    S_POLL_VALID,
    S_RD_DIG,
    S_DONE,
    S_ZEROIZE,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [511:0]        blk_q;
  logic                first_q;
  logic                mode_q;
  logic [3:0]          word_idx_q;
  logic [POLL_W-1:0]   poll_q;
  logic [255:0]        dig_q;
  logic                poll_last;
  logic                ready_bit;
  logic                valid_bit;

  assign poll_last = (poll_q == POLL_W'(TIMEOUT - 1));
  assign ready_bit = read_data[0];
  assign valid_bit = read_data[1];
  assign dig_data  = dig_q;

  // NOTE: state and datapath registers are only ever assigned with <=, so every
  // flop samples the values from before the edge regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output and state_d gets a default before the case statement, so
  // no path through the logic can leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    blk_ready  = 1'b0;
    dig_valid  = 1'b0;
    drv_error  = 1'b0;
    cs         = 1'b0;
    we         = 1'b0;
    address    = '0;
    write_data = '0;

    unique case (state_q)
      S_IDLE: begin
        // Do not advertise acceptance while reset is held.
        blk_ready = ~rst;
        if (blk_valid && !rst) state_d = S_WAIT_RDY;
      end

      S_WAIT_RDY: begin
        cs      = 1'b1;
        address = STATUS_ADDR;
        if (err)            state_d = S_ERR;
        else if (ready_bit) state_d = S_WR_BLK;
        else if (poll_last) state_d = S_ERR;
      end

      S_WR_BLK: begin
        cs         = 1'b1;
        we         = 1'b1;
        address    = BLOCK_ADDR + ADDR_WIDTH'({word_idx_q, 2'b00});
        // blk_q shifts left after every write, so the current word is always on top.
        write_data = blk_q[511 -: DATA_WIDTH];
        if (err)                     state_d = S_ERR;
        else if (word_idx_q == 4'd15) state_d = S_WR_CTRL;
      end

      S_WR_CTRL: begin
        cs         = 1'b1;
        we         = 1'b1;
        address    = CTRL_ADDR;
        write_data = DATA_WIDTH'({mode_q, ~first_q, first_q});
        state_d    = err ? S_ERR : S_POLL_BUSY;
      end

      S_POLL_BUSY: begin
        // Waiting for READY to drop proves the core picked up the command; a
        // VALID left over from the previous block is ignored here.
        cs      = 1'b1;
        address = STATUS_ADDR;
        if (err)            state_d = S_ERR;
        else if (!ready_bit) state_d = S_POLL_VALID;
        else if (poll_last) state_d = S_ERR;
      end

      S_POLL_VALID: begin
        cs      = 1'b1;
        address = STATUS_ADDR;
        if (err)                         state_d = S_ERR;
        else if (ready_bit && valid_bit) state_d = S_RD_DIG;
        else if (poll_last)              state_d = S_ERR;
      end

      S_RD_DIG: begin
        cs      = 1'b1;
        address = DIGEST_ADDR + ADDR_WIDTH'({word_idx_q, 2'b00});
        if (err)                     state_d = S_ERR;
        else if (word_idx_q == 4'd7) state_d = S_DONE;
      end

      S_DONE: begin
        dig_valid = 1'b1;
        if (dig_ready) begin
`ifdef SHA256_DRV_ZEROIZE_EN
          state_d = S_ZEROIZE;
`else
          state_d = S_IDLE;
`endif
        end
      end

`ifdef SHA256_DRV_ZEROIZE_EN
      S_ZEROIZE: begin
        cs         = 1'b1;
        we         = 1'b1;
        address    = CTRL_ADDR;
        write_data = DATA_WIDTH'(4'h8);
        state_d    = err ? S_ERR : S_IDLE;
      end
`endif

      S_ERR: begin
        drv_error = 1'b1;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the block payload register has no reset; it is loaded at every
  // handshake and never observed before that, so resetting 512 flops buys nothing.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && blk_valid)
      blk_q <= blk_data;
    else if (state_q == S_WR_BLK)
      blk_q <= blk_q << DATA_WIDTH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first_q    <= 1'b0;
      mode_q     <= 1'b0;
      word_idx_q <= '0;
      poll_q     <= '0;
      dig_q      <= '0;
    end else begin
      if (state_q == S_IDLE && blk_valid) begin
        first_q <= blk_first;
        mode_q  <= blk_mode;
      end

      // Word index and poll counter restart on every state change, which covers
      // entry to each burst and each wait phase.
      if (state_d != state_q)
        word_idx_q <= '0;
      else if (state_q == S_WR_BLK || state_q == S_RD_DIG)
        word_idx_q <= word_idx_q + 4'd1;

      if (state_d != state_q)
        poll_q <= '0;
      else if (state_q == S_WAIT_RDY || state_q == S_POLL_BUSY ||
               state_q == S_POLL_VALID)
        poll_q <= poll_q + POLL_W'(1);

      // DIGEST[0] is read first and ends up in the top slice after 8 shifts;
      // an errored read is discarded.
      if (state_q == S_RD_DIG && !err)
        dig_q <= {dig_q[255-DATA_WIDTH:0], read_data};
`ifdef SHA256_DRV_ZEROIZE_EN
      else if (state_q == S_DONE && dig_ready)
        dig_q <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_sha256_reg_driver.sv
// ---------------------------------------------------------------------------
// tb_sha256_reg_driver
//   Scoreboard bench for sha256_reg_driver. A behavioural register-block model
//   answers STATUS/DIGEST reads and can inject err or hold READY low. Expected
//   bus writes and digests are queued when a block is submitted and compared
//   by a negedge monitor as the DUT produces them.
//   Honours SHA256_DRV_ZEROIZE_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_sha256_reg_driver;

  localparam logic [31:0] CTRL_A   = 32'h10;
  localparam logic [31:0] STATUS_A = 32'h18;
  localparam logic [31:0] BLOCK_A  = 32'h80;
  localparam logic [31:0] DIGEST_A = 32'h100;
  localparam int          BUSY_LEN = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         blk_valid = 1'b0;
  logic         blk_ready;
  logic [511:0] blk_data = '0;
  logic         blk_first = 1'b0;
  logic         blk_mode = 1'b0;
  logic         dig_valid;
  logic         dig_ready = 1'b0;
  logic [255:0] dig_data;
  logic         drv_error;
  logic         cs, we;
  logic [31:0]  address;
  logic [31:0]  write_data;
  logic [31:0]  read_data;
  logic         err;

  always #5 clk = ~clk;

  sha256_reg_driver dut (
    .clk(clk), .rst(rst),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_first(blk_first), .blk_mode(blk_mode),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data),
    .drv_error(drv_error),
    .cs(cs), .we(we), .address(address), .write_data(write_data),
    .read_data(read_data), .err(err)
  );

  // ---------------- checking ----------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // ---------------- register block model ----------------
  logic [31:0] dig_mem [8];
  int          busy = 0;
  logic        valid_m = 1'b0;
  bit          hold_nr = 1'b0;
  bit          inject = 1'b0;
  int          err_at = -1;
  int          blk_wr_total = 0;
  logic [31:0] status_v;
  logic [31:0] dig_off;
  logic        in_blk;

  assign in_blk = (address >= BLOCK_A) && (address <= BLOCK_A + 32'd60);
  assign err    = inject && cs && we && in_blk && (blk_wr_total == err_at);

  always_comb begin
    status_v = '0;
    if (!hold_nr && busy == 0) status_v = {30'b0, valid_m, 1'b1};
  end

  always_comb begin
    read_data = '0;
    dig_off   = address - DIGEST_A;
    if (address == STATUS_A) read_data = status_v;
    else if (address >= DIGEST_A && address < DIGEST_A + 32'd32)
      read_data = dig_mem[dig_off[4:2]];
  end

  always @(posedge clk) begin
    if (cs && we && address == CTRL_A && write_data[1:0] != 2'b00) begin
      busy    <= BUSY_LEN;
      valid_m <= 1'b0;
    end else if (busy > 0) begin
      busy <= busy - 1;
      if (busy == 1) valid_m <= 1'b1;
    end
    if (cs && we && in_blk) blk_wr_total <= blk_wr_total + 1;
  end

  // ---------------- scoreboard ----------------
  logic [63:0]  exp_wr_q [$];
  logic [255:0] exp_dig_q [$];
  int           status_reads = 0;
  int           dig_cycles = 0;

  always @(negedge clk) begin
    logic [63:0]  e;
    logic [255:0] d;
    if (cs && we) begin
      check("wr_pending", exp_wr_q.size() != 0, 1);
      if (exp_wr_q.size() != 0) begin
        e = exp_wr_q.pop_front();
        check("wr_addr", address, e[63:32]);
        check("wr_data", write_data, e[31:0]);
      end
    end
    if (cs && !we && address == STATUS_A) status_reads++;
    if (dig_valid) dig_cycles++;
    if (dig_valid && dig_ready) begin
      check("dig_pending", exp_dig_q.size() != 0, 1);
      if (exp_dig_q.size() != 0) begin
        d = exp_dig_q.pop_front();
        check("dig_data", dig_data, d);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_digest(input logic [255:0] d);
    for (int i = 0; i < 8; i++) dig_mem[i] = d[255-32*i -: 32];
  endtask

  // Queue the first n expected writes of a block (16 BLOCK words, then CTRL).
  task automatic push_writes(input logic [511:0] b, input logic [31:0] ctrl, input int n);
    for (int i = 0; i < 16 && i < n; i++)
      exp_wr_q.push_back({BLOCK_A + 32'(4 * i), b[511-32*i -: 32]});
    if (n > 16) exp_wr_q.push_back({CTRL_A, ctrl});
  endtask

  task automatic send_block(input logic [511:0] b, input logic first, input logic mode);
    int w;
    blk_data  = b;
    blk_first = first;
    blk_mode  = mode;
    blk_valid = 1'b1;
    w = 0;
    while (!blk_ready && w < 50) begin
      tick();
      w++;
    end
    check("blk_ready_seen", blk_ready, 1);
    @(posedge clk);
    #1;
    blk_valid = 1'b0;
    blk_data  = ~b;           // must be ignored after the handshake
    blk_first = ~first;
    blk_mode  = ~mode;
    check("blk_ready_busy", blk_ready, 0);
  endtask

  // Wait for the digest, hold dig_ready low for `hold` cycles, then consume it.
  task automatic take_digest(input int hold, input logic [255:0] exp, output int lat);
    lat = 1;
    while (!dig_valid && lat < 300) begin
      tick();
      lat++;
    end
    check("dig_valid_seen", dig_valid, 1);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("dig_hold_valid", dig_valid, 1);
      check("dig_hold_data", dig_data, exp);
    end
    exp_dig_q.push_back(exp);
`ifdef SHA256_DRV_ZEROIZE_EN
    exp_wr_q.push_back({CTRL_A, 32'h8});
`endif
    dig_ready = 1'b1;
    tick();
    dig_ready = 1'b0;
    check("dig_valid_drop", dig_valid, 0);
`ifdef SHA256_DRV_ZEROIZE_EN
    check("dig_zeroized", dig_data, '0);
`else
    check("dig_retained", dig_data, exp);
`endif
    tick();
    check("back_idle", blk_ready, 1);
  endtask

  // ---------------- test vectors ----------------
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] NIST_DIG =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  // Intermediate digest the model returns after the first NIST block.
  localparam logic [255:0] MID_DIG =
    256'h01234567_89abcdef_fedcba98_76543210_0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
  localparam logic [255:0] ALT_DIG =
    256'hdeadbeef_cafef00d_11223344_55667788_99aabbcc_ddeeff00_a5a5a5a5_5a5a5a5a;

  logic [511:0] abc_blk, m1_blk, m2_blk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int lat, w, s0, d0;

    abc_blk = '0;
    abc_blk[511:480] = 32'h61626380;
    abc_blk[31:0]    = 32'h00000018;
    m1_blk = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
              32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
              32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
              32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    m2_blk = '0;
    m2_blk[31:0] = 32'h000001c0;
    load_digest('0);

    // Reset state
    blk_valid = 1'b1;
    repeat (3) tick();
    check("rst_blk_ready", blk_ready, 0);
    check("rst_cs", cs, 0);
    check("rst_dig_valid", dig_valid, 0);
    check("rst_drv_error", drv_error, 0);
    check("rst_dig_data", dig_data, '0);
    blk_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("idle_blk_ready", blk_ready, 1);

    // "abc": INIT, SHA-256, latency with W=1, B=1, V=3
    load_digest(ABC_DIG);
    push_writes(abc_blk, 32'h5, 17);
    send_block(abc_blk, 1'b1, 1'b1);
    take_digest(0, ABC_DIG, lat);
    check("latency", lat, 1 + 1 + 16 + 1 + 1 + BUSY_LEN + 8);

    // Two-block NIST message: INIT then NEXT, second digest held 20 cycles
    load_digest(MID_DIG);
    push_writes(m1_blk, 32'h5, 17);
    send_block(m1_blk, 1'b1, 1'b1);
    take_digest(2, MID_DIG, lat);
    load_digest(NIST_DIG);
    push_writes(m2_blk, 32'h6, 17);
    send_block(m2_blk, 1'b0, 1'b1);
    take_digest(20, NIST_DIG, lat);

    // SHA-224 mode, INIT: CTRL = 'h1
    load_digest(ALT_DIG);
    push_writes(m1_blk, 32'h1, 17);
    send_block(m1_blk, 1'b1, 1'b0);
    take_digest(1, ALT_DIG, lat);

    // READY held low: exactly 1023 STATUS polls, then a one-cycle error
    hold_nr = 1'b1;
    s0 = status_reads;
    d0 = dig_cycles;
    send_block(abc_blk, 1'b1, 1'b1);
    w = 0;
    while (!drv_error && w < 2000) begin
      tick();
      w++;
    end
    check("tmo_err_seen", drv_error, 1);
    check("tmo_polls", status_reads - s0, 1023);
    tick();
    check("tmo_err_pulse", drv_error, 0);
    check("tmo_blk_ready", blk_ready, 1);
    hold_nr = 1'b0;

    // err on the 5th BLOCK write: nothing after it, no digest
    err_at = blk_wr_total + 4;
    inject = 1'b1;
    push_writes(m2_blk, 32'h0, 5);
    send_block(m2_blk, 1'b1, 1'b1);
    w = 0;
    while (!drv_error && w < 100) begin
      tick();
      w++;
    end
    check("berr_err_seen", drv_error, 1);
    tick();
    check("berr_err_pulse", drv_error, 0);
    check("berr_blk_ready", blk_ready, 1);
    inject = 1'b0;
    repeat (5) tick();
    check("berr_wr_left", exp_wr_q.size(), 0);
    check("no_dig_on_error", dig_cycles - d0, 0);

    // Reset during BLOCK write 8: bus goes quiet on the next cycle
    push_writes(abc_blk, 32'h5, 8);
    send_block(abc_blk, 1'b1, 1'b1);
    w = 0;
    while (!(cs && we && address == BLOCK_A + 32'd28) && w < 50) begin
      tick();
      w++;
    end
    check("rst8_reached", address, BLOCK_A + 32'd28);
    rst = 1'b1;
    tick();
    check("rst8_cs", cs, 0);
    check("rst8_blk_ready", blk_ready, 0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();
    check("rst8_idle", blk_ready, 1);
    check("rst8_dig_data", dig_data, '0);

    check("wr_q_empty", exp_wr_q.size(), 0);
    check("dig_q_empty", exp_dig_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
